md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Sequencer for the E-stage multiply/divide resource: accepts one mult/multu/div/divu issue, holds
//  busy for a fixed latency, then commits HI/LO. Also services mthi/mtlo and feeds mfhi/mflo.
//  Supplies busy to hazardUnit (stall md instrs in D) and honours the interrupt flush so a flushed
//  E-stage issue never starts.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-high; clears all state
//  start     in   1   issue request from E-stage decode (one cycle per instr)
//  op        in   2   00 mult, 01 multu, 10 div, 11 divu; sampled with start
//  src_a     in   32  rs operand (forwarded MFRSE)
//  src_b     in   32  rt operand (forwarded MFRTE)
//  cancel    in   1   interrupt/exception flush of E stage this cycle
//  wr_hi     in   1   mthi in E
//  wr_lo     in   1   mtlo in E
//  wr_data   in   32  mthi/mtlo data (forwarded MFRSE)
//  busy      out  1   operation in flight
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset (async): state IDLE, count 0, busy 0, hi 0, lo 0, pending result regs 0.
//  - FSM: IDLE, RUN. IDLE->RUN on accepted start; RUN->IDLE when count reaches 1; no other states.
//  - Accept rule: start && !cancel && state==IDLE. cancel in same cycle: start ignored, no state change.
//  - On accept edge: result computed from src_a/src_b/op and latched into pend_hi/pend_lo; count loaded
//    with MULT_CYCLES or DIV_CYCLES by op[1]; busy=1 from the next cycle.
//  - RUN: count decrements each edge; on edge where count==1: hi<=pend_hi, lo<=pend_lo, busy->0.
//    Hence busy high exactly N cycles; new hi/lo visible in cycle N+1 after start cycle.
//  - cancel while RUN: no effect (in-flight op belongs to an older, committed instruction).
//  - start while RUN: ignored (hazardUnit must prevent it); operands not relatched.
//  - mult: {hi,lo}=signed 64-bit product; multu: unsigned product.
//  - div: lo=quotient truncated toward zero, hi=remainder with sign of dividend; divu unsigned.
//  - div/divu by zero: full DIV_CYCLES busy, hi/lo unchanged at commit (pend loaded with current hi/lo).
//  - 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0, no trap.
//  - wr_hi/wr_lo: applied on edge when !cancel && state==IDLE && !start; otherwise ignored.
//    wr_hi and wr_lo together: both written with wr_data.
//  - hi/lo outputs are register values; no bypass of pending results or same-cycle mthi/mtlo.
//  - reset mid-RUN: aborts immediately, hi/lo cleared, busy 0.
// TESTING
//  T1 mult src_a=0xFFFFFFFE src_b=3 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA; multu same -> hi=2 lo=0xFFFFFFFA.
//  T2 div src_a=0xFFFFFFF9(-7) src_b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3 hi=1.
//  T3 wr_hi 0x1234, wr_lo 0x5678, then divu by 0 -> busy 10 cycles, hi=0x1234 lo=0x5678 unchanged.
//  T4 start with cancel=1 -> busy stays 0, hi/lo unchanged; cancel=1 mid-RUN -> commit still at cycle N.
//  T5 start while busy (op mult 2*3) -> ignored, original result commits; wr_lo during RUN ignored.
//  T6 assert reset at count 3 of a div -> busy 0, hi=lo=0 asynchronously; next start runs normally.

Source files
------------

// File: rtl/md_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer_if
// Description : Issue / move-to / result bundle for the E-stage mult-div unit.
// Revision    : 1.0  initial release
// ============================================================================
interface md_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel, wr_hi, wr_lo, wr_data,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, wr_hi, wr_lo, wr_data,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer
// Description : Fixed-latency mult/div sequencer owning HI/LO, with mthi/mtlo.
// Revision    : 1.0  initial release
// ============================================================================
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  bus
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_cnt  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_busy;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;

    logic                 w_accept;
    logic                 w_move;
    logic [63:0]          w_prod_s;
    logic [63:0]          w_prod_u;
    logic                 w_is_signed;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [31:0]          w_mag_a;
    logic [31:0]          w_mag_b;
    logic [31:0]          w_den;
    logic [31:0]          w_q_mag;
    logic [31:0]          w_r_mag;
    logic [31:0]          w_quot;
    logic [31:0]          w_rem;
    logic                 w_div_zero;
    logic [31:0]          w_next_hi;
    logic [31:0]          w_next_lo;

    assign w_accept = bus.start && !bus.cancel && (r_state == IDLE);
    assign w_move   = !bus.cancel && (r_state == IDLE) && !bus.start;

    assign w_prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a})
                    * $signed({{32{bus.src_b[31]}}, bus.src_b});
    assign w_prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};

    // Signed division runs on magnitudes and re-applies signs, which also
    // yields 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
    assign w_is_signed = !bus.op[0];
    assign w_neg_a     = w_is_signed && bus.src_a[31];
    assign w_neg_b     = w_is_signed && bus.src_b[31];
    assign w_mag_a     = w_neg_a ? (~bus.src_a + 32'd1) : bus.src_a;
    assign w_mag_b     = w_neg_b ? (~bus.src_b + 32'd1) : bus.src_b;
    assign w_div_zero  = (bus.src_b == 32'd0);
    assign w_den       = w_div_zero ? 32'd1 : w_mag_b;
    assign w_q_mag     = w_mag_a / w_den;
    assign w_r_mag     = w_mag_a % w_den;
    assign w_quot      = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem       = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_next_hi = r_hi;
        w_next_lo = r_lo;
        case (bus.op)
            2'b00: begin
                w_next_hi = w_prod_s[63:32];
                w_next_lo = w_prod_s[31:0];
            end
            2'b01: begin
                w_next_hi = w_prod_u[63:32];
                w_next_lo = w_prod_u[31:0];
            end
            default: begin
                // Divide by zero commits the current HI/LO back unchanged.
                if (!w_div_zero) begin
                    w_next_hi = w_rem;
                    w_next_lo = w_quot;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pend_hi <= w_next_hi;
                        r_pend_lo <= w_next_lo;
                        r_count   <= bus.op[1] ? c_div_cnt : c_mult_cnt;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end else if (w_move) begin
                        if (bus.wr_hi) begin
                            r_hi <= bus.wr_data;
                        end
                        if (bus.wr_lo) begin
                            r_lo <= bus.wr_data;
                        end
                    end
                end
                RUN: begin
                    if (r_count == c_cnt_one) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_count <= r_count - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_sequencer
// Description : Directed self-checking bench for md_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_md_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_sequencer_if bus ();

    md_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = 32'd0;
        bus.src_b   = 32'd0;
        bus.cancel  = 1'b0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = 32'd0;
    endtask

    // Issue one op, check busy and held HI/LO each busy cycle, then the commit.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int inj_cancel, input int inj_start,
                          input int inj_wrlo, input bit wr_with_start);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        if (wr_with_start) begin
            bus.wr_hi   = 1'b1;
            bus.wr_data = 32'hFFFF_0000;
        end
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            chk({tag, "_hold_hi"}, bus.hi, exp_hi);
            chk({tag, "_hold_lo"}, bus.lo, exp_lo);
            bus.cancel = (i == inj_cancel);
            bus.start  = (i == inj_start);
            if (i == inj_start) begin
                bus.op    = 2'b00;
                bus.src_a = 32'd2;
                bus.src_b = 32'd3;
            end
            bus.wr_lo   = (i == inj_wrlo);
            bus.wr_data = 32'hDEAD_BEEF;
            @(negedge clk);
            idle_inputs();
        end
        chk({tag, "_done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_hi"}, bus.hi, ehi);
        chk({tag, "_lo"}, bus.lo, elo);
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    task automatic move(input string tag, input bit h, input bit l,
                        input logic [31:0] d, input bit cx);
        @(negedge clk);
        bus.wr_hi   = h;
        bus.wr_lo   = l;
        bus.wr_data = d;
        bus.cancel  = cx;
        @(negedge clk);
        idle_inputs();
        if (!cx && h) exp_hi = d;
        if (!cx && l) exp_lo = d;
        chk({tag, "_hi"}, bus.hi, exp_hi);
        chk({tag, "_lo"}, bus.lo, exp_lo);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;

        // T1 multiply, signed and unsigned
        run_op("mult",  2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1, -1, -1, 1'b0);
        run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, -1, -1, -1, 1'b0);

        // T2 divide, signed and unsigned, plus the overflow corner
        run_op("div",   2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1, -1, 1'b0);
        run_op("divu",  2'b11, 32'd7, 32'd2, 10, 32'd1, 32'd3, -1, -1, -1, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, -1, -1, -1, 1'b0);
        run_op("div_neg_b", 2'b10, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, -1, -1, -1, 1'b0);

        // T3 moves, then divide by zero leaves HI/LO alone
        move("mthi", 1'b1, 1'b0, 32'h0000_1234, 1'b0);
        move("mtlo", 1'b0, 1'b1, 32'h0000_5678, 1'b0);
        run_op("divu_z", 2'b11, 32'd5, 32'd0, 10, 32'h0000_1234, 32'h0000_5678, -1, -1, -1, 1'b0);
        run_op("div_z",  2'b10, 32'hFFFF_FFFB, 32'd0, 10, 32'h0000_1234, 32'h0000_5678, -1, -1, -1, 1'b0);
        move("mt_both", 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
        move("mthi_cx", 1'b1, 1'b0, 32'h0000_1111, 1'b1);

        // T4 start squashed by cancel, then cancel during RUN
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'b00;
        bus.src_a  = 32'd5;
        bus.src_b  = 32'd5;
        bus.cancel = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("cx_start_busy", {31'd0, bus.busy}, 32'd0);
        chk("cx_start_hi", bus.hi, exp_hi);
        @(negedge clk);
        chk("cx_start_busy2", {31'd0, bus.busy}, 32'd0);
        chk("cx_start_lo", bus.lo, exp_lo);
        run_op("mult_cx", 2'b00, 32'd3, 32'd4, 5, 32'd0, 32'd12, 2, -1, -1, 1'b1);
        run_op("mult_cx_end", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd0, 32'd1, 4, -1, -1, 1'b0);

        // T5 start and mtlo while RUN are ignored
        run_op("multu_ign", 2'b01, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0, -1, 1, 3, 1'b0);
        run_op("div_ign",   2'b10, 32'd100, 32'd7, 10, 32'd2, 32'd14, -1, 9, 9, 1'b0);

        // T6 asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(negedge clk);
        idle_inputs();
        repeat (7) @(negedge clk);
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_hi", bus.hi, 32'd0);
        chk("arst_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        run_op("post_rst", 2'b00, 32'd3, 32'd4, 5, 32'd0, 32'd12, -1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
